// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port 64-bit memory between instruction fetch (IF) and data (D).
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed D priority.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic          d_err,
  output logic [63:0]   d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  output logic          mem_wr,
  input  logic [63:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic        owner;
  logic        err_flag;
  logic        store_flag;
  logic        word_sel;
  logic [2:0]  cnt;
  logic [31:0] if_rdata_q;
  logic [63:0] d_rdata_q;
  logic        win_d;
  logic        d_misaligned;
  logic        resp_ok;

  assign d_misaligned = (d_addr[2:0] != 3'b000);

`ifdef MEM_ARB_RR_EN
  // rr_ptr = 0 prefers D, 1 prefers IF; it only moves when both ports compete.
  logic rr_ptr;

  always_comb begin
    win_d = d_req && (!if_req || !rr_ptr);
  end

  always_ff @(posedge CLK) begin
    if (RST)
      rr_ptr <= 1'b0;
    else if (state == IDLE && if_req && d_req)
      rr_ptr <= ~rr_ptr;
  end
`else
  assign win_d = d_req;
`endif

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (!RST && (if_req || d_req)) begin
          if (win_d) d_gnt = 1'b1;
          else       if_gnt = 1'b1;
          state_nxt = (win_d && d_misaligned) ? RESP : LAUNCH;
        end
      end
      LAUNCH:  state_nxt = (LAT_M1 == 3'd0) ? RESP : WAIT;
      WAIT:    if (cnt <= 3'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= 1'b0;
      err_flag   <= 1'b0;
      store_flag <= 1'b0;
      word_sel   <= 1'b0;
      cnt        <= 3'd0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state  <= state_nxt;
      mem_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt || d_gnt) begin
            owner      <= d_gnt;
            err_flag   <= d_gnt && d_misaligned;
            store_flag <= d_gnt && d_we;
            word_sel   <= if_addr[2];
            if (if_gnt) begin
              mem_addr <= if_addr;
            end else if (!d_misaligned) begin
              mem_addr <= d_addr;
              if (d_we) begin
                mem_wdata <= d_wdata;
                mem_wr    <= 1'b1;
              end
            end
          end
        end
        LAUNCH: cnt <= LAT_M1;
        WAIT:   cnt <= cnt - 3'd1;
        RESP: begin
          if (!owner)
            if_rdata_q <= word_sel ? mem_rdata[63:32] : mem_rdata[31:0];
          else if (!err_flag && !store_flag)
            d_rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Response data is forwarded in the RESP cycle so it is valid alongside rvalid.
  assign resp_ok   = (state == RESP) && !RST;
  assign if_rvalid = resp_ok && !owner;
  assign d_rvalid  = resp_ok && owner;
  assign d_err     = d_rvalid && err_flag;
  assign if_rdata  = if_rvalid ? (word_sel ? mem_rdata[63:32] : mem_rdata[31:0]) : if_rdata_q;
  assign d_rdata   = (d_rvalid && !err_flag && !store_flag) ? mem_rdata : d_rdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a cycle-level transaction model predicts grants,
// responses and memory-side activity. Build with +define+MEM_ARB_RR_EN to check round-robin.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 3;
  localparam int AW      = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [63:0]   d_rdata;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic          mem_wr;
  logic [63:0]   mem_rdata;
  logic          busy;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Memory with a read pipeline of MEM_LAT stages behind the registered address.
  logic [63:0]   phys_mem [256];
  logic [AW-1:0] addr_pipe [MEM_LAT];
  logic [AW-1:0] rd_addr;
  assign rd_addr   = addr_pipe[MEM_LAT-1];
  assign mem_rdata = phys_mem[rd_addr[10:3]];

  always @(posedge CLK) begin
    addr_pipe[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    if (mem_wr) phys_mem[mem_addr[10:3]] <= mem_wdata;
  end

  int checks   = 0;
  int failures = 0;

  logic [63:0]   model_mem [256];
  int            cyc, free_at, gnt_cycle, resp_cycle, wr_cycle;
  logic          resp_is_d, resp_err, resp_d_upd;
  logic [31:0]   resp_if_data, exp_if_rdata;
  logic [63:0]   resp_d_data, exp_d_rdata, exp_mem_wdata;
  logic [AW-1:0] exp_mem_addr;
  logic          clr_if, clr_d;
  logic          rr_pref;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s @cyc %0d: got %h expected %h", tag, cyc, actual, expected);
    end
  endtask

  // Transaction-level model: a grant is possible once the previous access has fully
  // retired; an access occupies the port for its latency plus one cycle.
  task automatic evalCycle();
    logic e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err, e_busy, e_wr, win;
    logic new_addr_ok, new_wdata_ok;
    logic [AW-1:0] new_addr;
    logic [63:0] new_wdata;
    logic [7:0] k;
    int lat;
    e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_err = 0;
    new_addr_ok = 0; new_wdata_ok = 0; new_addr = '0; new_wdata = '0; lat = 0;
    e_busy = (cyc > gnt_cycle) && (cyc < free_at);
    e_wr   = (cyc == wr_cycle);
    if (!RST && cyc == resp_cycle) begin
      if (resp_is_d) begin
        e_d_rv = 1; e_err = resp_err;
        if (resp_d_upd) exp_d_rdata = resp_d_data;
      end else begin
        e_if_rv = 1; exp_if_rdata = resp_if_data;
      end
    end
    if (!RST && cyc >= free_at && (if_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
      if (if_req && d_req) begin
        win = !rr_pref;
        rr_pref = !rr_pref;
      end else begin
        win = d_req;
      end
`else
      win = d_req;
`endif
      gnt_cycle = cyc;
      if (win) begin
        e_d_gnt = 1; clr_d = 1; resp_is_d = 1;
        if (d_addr[2:0] != 3'b000) begin
          lat = 1; resp_err = 1; resp_d_upd = 0;
        end else begin
          lat = MEM_LAT + 1; resp_err = 0;
          new_addr_ok = 1; new_addr = d_addr; k = d_addr[10:3];
          if (d_we) begin
            model_mem[k] = d_wdata; resp_d_upd = 0; wr_cycle = cyc + 1;
            new_wdata_ok = 1; new_wdata = d_wdata;
          end else begin
            resp_d_upd = 1; resp_d_data = model_mem[k];
          end
        end
      end else begin
        e_if_gnt = 1; clr_if = 1; resp_is_d = 0; lat = MEM_LAT + 1;
        new_addr_ok = 1; new_addr = if_addr; k = if_addr[10:3];
        resp_if_data = if_addr[2] ? model_mem[k][63:32] : model_mem[k][31:0];
      end
      resp_cycle = cyc + lat;
      free_at    = cyc + lat + 1;
    end
    checkOutput("if_gnt", 64'(if_gnt), 64'(e_if_gnt));
    checkOutput("d_gnt", 64'(d_gnt), 64'(e_d_gnt));
    checkOutput("if_rvalid", 64'(if_rvalid), 64'(e_if_rv));
    checkOutput("d_rvalid", 64'(d_rvalid), 64'(e_d_rv));
    checkOutput("d_err", 64'(d_err), 64'(e_err));
    checkOutput("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    checkOutput("d_rdata", d_rdata, exp_d_rdata);
    checkOutput("mem_wr", 64'(mem_wr), 64'(e_wr));
    checkOutput("mem_addr", mem_addr, exp_mem_addr);
    checkOutput("mem_wdata", mem_wdata, exp_mem_wdata);
    checkOutput("busy", 64'(busy), 64'(e_busy));
    if (RST) begin
      exp_if_rdata = '0; exp_d_rdata = '0; exp_mem_addr = '0; exp_mem_wdata = '0;
      free_at = cyc + 1; resp_cycle = -1; wr_cycle = -1; rr_pref = 0;
    end else begin
      if (new_addr_ok) exp_mem_addr = new_addr;
      if (new_wdata_ok) exp_mem_wdata = new_wdata;
    end
  endtask

  task automatic stepCycle();
    @(negedge CLK);
    evalCycle();
    @(posedge CLK);
    #1;
    if (clr_if) if_req = 0;
    if (clr_d) d_req = 0;
    clr_if = 0; clr_d = 0; RST = 0;
    cyc++;
  endtask

  task automatic runUntilIdle();
    for (int i = 0; i < 200 && (if_req || d_req || cyc < free_at); i++) stepCycle();
    checkOutput("idle_timeout", 64'(if_req || d_req || cyc < free_at), 64'd0);
  endtask

  task automatic applyStimulus();
    if (!if_req && $urandom_range(0, 3) == 0) begin
      if_req = 1;
      if_addr = 64'($urandom_range(0, 511)) << 2;
    end else if (if_req && $urandom_range(0, 49) == 0) begin
      if_req = 0;
    end
    if (!d_req && $urandom_range(0, 3) == 0) begin
      d_req = 1;
      d_we = 1'($urandom_range(0, 1));
      d_wdata = {$urandom, $urandom};
      d_addr = 64'($urandom_range(0, 255)) << 3;
      if ($urandom_range(0, 5) == 0) d_addr = d_addr | 64'($urandom_range(1, 7));
    end else if (d_req && $urandom_range(0, 49) == 0) begin
      d_req = 0;
    end
    if (!RST && cyc > gnt_cycle + 1 && cyc < free_at && $urandom_range(0, 99) == 0) RST = 1;
  endtask

  initial begin
    logic [63:0] v;
    int g0;
    RST = 1; if_req = 1; if_addr = 64'h10;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    clr_if = 0; clr_d = 0; rr_pref = 0;
    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom};
      model_mem[i] = v;
      phys_mem[i] <= v;
    end
    model_mem[2] = 64'h00000013_00000093;
    phys_mem[2] <= 64'h00000013_00000093;
    cyc = 0; free_at = 0; gnt_cycle = -1; resp_cycle = -1; wr_cycle = -1;
    exp_if_rdata = '0; exp_d_rdata = '0; exp_mem_addr = '0; exp_mem_wdata = '0;
    resp_is_d = 0; resp_err = 0; resp_d_upd = 0; resp_if_data = '0; resp_d_data = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_if_gnt", 64'(if_gnt), 64'd0);
    checkOutput("rst_d_gnt", 64'(d_gnt), 64'd0);
    checkOutput("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    checkOutput("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    checkOutput("rst_d_err", 64'(d_err), 64'd0);
    checkOutput("rst_if_rdata", 64'(if_rdata), 64'd0);
    checkOutput("rst_d_rdata", d_rdata, 64'd0);
    checkOutput("rst_mem_addr", mem_addr, 64'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
    checkOutput("rst_mem_wr", 64'(mem_wr), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    @(posedge CLK);
    #1;
    RST = 0;

    // Lower then upper instruction word of the same doubleword.
    runUntilIdle();
    checkOutput("fetch_lo", 64'(if_rdata), 64'h00000093);
    if_req = 1; if_addr = 64'h14;
    runUntilIdle();
    checkOutput("fetch_hi", 64'(if_rdata), 64'h00000013);

    d_req = 1; d_we = 1; d_addr = 64'h40; d_wdata = 64'hDEADBEEF_CAFEF00D;
    runUntilIdle();
    d_req = 1; d_we = 0; d_addr = 64'h40;
    runUntilIdle();
    checkOutput("store_load", d_rdata, 64'hDEADBEEF_CAFEF00D);

    // Two back-to-back conflicts.
    for (int n = 0; n < 2; n++) begin
      if_req = 1; if_addr = 64'h10;
      d_req = 1; d_we = 0; d_addr = 64'h40;
      runUntilIdle();
    end

    d_req = 1; d_we = 0; d_addr = 64'h43;
    runUntilIdle();
    d_req = 1; d_we = 1; d_addr = 64'h45; d_wdata = 64'h1111_2222_3333_4444;
    runUntilIdle();

    // Reset while the fetch is waiting on memory, then a normal fetch.
    if_req = 1; if_addr = 64'h18;
    g0 = gnt_cycle;
    for (int i = 0; i < 20 && gnt_cycle == g0; i++) stepCycle();
    stepCycle();
    RST = 1;
    stepCycle();
    if_req = 1; if_addr = 64'h10;
    runUntilIdle();
    checkOutput("fetch_after_rst", 64'(if_rdata), 64'h00000093);

    repeat (1500) begin
      applyStimulus();
      stepCycle();
    end
    runUntilIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
